pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipelined core.
- Drives the write-enable and clear inputs of the PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves three hazard classes: load-use data hazards, taken-branch redirects and data-memory busy freezes.
- Maintains saturating performance counters of stall and flush cycles.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      FLUSH      = 2'd1,
      LOAD_STALL = 2'd2
   } state_e;

   localparam int REG_ZERO       = 0;
   localparam int REG_ADDR_W_DEF = 5;
   localparam int CNT_W_DEF      = 16;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: the EX load writes a register that the ID instruction reads.
module load_use_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  load_use
);

   logic rd_live;
   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      // x0 is hardwired, so a load targeting it never creates a dependency.
      rd_live  = ex_mem_read && (ex_rd != REG_ADDR_W'(REG_ZERO));
      rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
      rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
      load_use = rd_live && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, branch flushes,
// data-memory freezes, plus saturating stall/flush cycle counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
   parameter int FLUSH_CYCLES = 1,
   parameter int LOAD_BUBBLES = 1,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_branch_taken,
   input  logic                  dmem_busy,
   output logic                  pc_we,
   output logic                  if_id_we,
   output logic                  if_id_clear,
   output logic                  id_ex_clear,
   output logic                  ex_mem_we,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam int DC_W = $clog2(max_int(FLUSH_CYCLES, LOAD_BUBBLES) + 1);

   state_e            state_q, state_d;
   logic [DC_W-1:0]   dcnt_q, dcnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              load_use;
   logic              redirect;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   load_use_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_load_use_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .load_use    (load_use)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         dcnt_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         dcnt_q      <= dcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // A taken branch only counts when it is actually acted on: RUN and not frozen.
   assign redirect = (state_q == RUN) && !dmem_busy && ex_branch_taken;

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      if (!dmem_busy) begin
         unique case (state_q)
            RUN: begin
               if (ex_branch_taken) begin
                  if (FLUSH_CYCLES > 1) begin
                     dcnt_d  = DC_W'(FLUSH_CYCLES - 1);
                     state_d = FLUSH;
                  end
               end else if (load_use) begin
                  if (LOAD_BUBBLES > 1) begin
                     dcnt_d  = DC_W'(LOAD_BUBBLES - 1);
                     state_d = LOAD_STALL;
                  end
               end
            end
            FLUSH, LOAD_STALL: begin
               dcnt_d = dcnt_q - 1'b1;
               if (dcnt_q <= DC_W'(1)) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin
      pc_we       = 1'b1;
      if_id_we    = 1'b1;
      ex_mem_we   = 1'b1;
      if_id_clear = 1'b0;
      id_ex_clear = 1'b0;
      if (!rst_n) begin
         pc_we       = 1'b0;
         if_id_we    = 1'b0;
         ex_mem_we   = 1'b0;
         if_id_clear = 1'b1;
         id_ex_clear = 1'b1;
      end else if (dmem_busy) begin
         pc_we     = 1'b0;
         if_id_we  = 1'b0;
         ex_mem_we = 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (ex_branch_taken) begin
                  if_id_clear = 1'b1;
                  id_ex_clear = 1'b1;
               end else if (load_use) begin
                  pc_we       = 1'b0;
                  if_id_we    = 1'b0;
                  id_ex_clear = 1'b1;
               end
            end
            FLUSH: begin
               if_id_clear = 1'b1;
               id_ex_clear = 1'b1;
            end
            LOAD_STALL: begin
               pc_we       = 1'b0;
               if_id_we    = 1'b0;
               id_ex_clear = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = pc_we ? stall_cnt_q : sat_inc(stall_cnt_q);
      flush_cnt_d = redirect ? sat_inc(flush_cnt_q) : flush_cnt_q;
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: instance A (FLUSH_CYCLES=2, LOAD_BUBBLES=1), instance B (1, 3), shared stimulus.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, dmem_busy;

   logic        pc_we_a, if_id_we_a, if_id_clear_a, id_ex_clear_a, ex_mem_we_a;
   logic [15:0] stall_cnt_a, flush_cnt_a;
   logic        pc_we_b, if_id_we_b, if_id_clear_b, id_ex_clear_b, ex_mem_we_b;
   logic [15:0] stall_cnt_b, flush_cnt_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .LOAD_BUBBLES(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
      .pc_we(pc_we_a), .if_id_we(if_id_we_a), .if_id_clear(if_id_clear_a),
      .id_ex_clear(id_ex_clear_a), .ex_mem_we(ex_mem_we_a),
      .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a));

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(1), .LOAD_BUBBLES(3), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
      .pc_we(pc_we_b), .if_id_we(if_id_we_b), .if_id_clear(if_id_clear_b),
      .id_ex_clear(id_ex_clear_b), .ex_mem_we(ex_mem_we_b),
      .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b));

   // Load-use vector table: read, rd, rs1, rs2, uses1, uses2, expected stall.
   logic       v_rd_en [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [4:0] v_rd    [5] = '{5'd0, 5'd7, 5'd7, 5'd7, 5'd9};
   logic [4:0] v_rs1   [5] = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd3};
   logic [4:0] v_rs2   [5] = '{5'd0, 5'd7, 5'd0, 5'd7, 5'd4};
   logic       v_u1    [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic       v_u2    [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic       v_exp   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; dmem_busy = 1'b0;
   endtask

   task automatic set_load5();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      repeat (3) tick();
      #1;
      total++; if (pc_we_a !== 1'b0) begin bad++; $display("FAIL rst_pc_we got=%0b exp=0", pc_we_a); end
      total++; if (if_id_we_a !== 1'b0) begin bad++; $display("FAIL rst_if_id_we got=%0b exp=0", if_id_we_a); end
      total++; if (ex_mem_we_a !== 1'b0) begin bad++; $display("FAIL rst_ex_mem_we got=%0b exp=0", ex_mem_we_a); end
      total++; if (if_id_clear_a !== 1'b1) begin bad++; $display("FAIL rst_if_id_clear got=%0b exp=1", if_id_clear_a); end
      total++; if (id_ex_clear_a !== 1'b1) begin bad++; $display("FAIL rst_id_ex_clear got=%0b exp=1", id_ex_clear_a); end
      total++; if (stall_cnt_a !== 16'd0 || flush_cnt_a !== 16'd0) begin bad++; $display("FAIL rst_cnts got=%0h/%0h exp=0/0", stall_cnt_a, flush_cnt_a); end
      rst_n = 1'b1;
      #1;
      total++; if ({pc_we_a, if_id_we_a, ex_mem_we_a, if_id_clear_a, id_ex_clear_a} !== 5'b11100) begin bad++; $display("FAIL idle_outputs got=%b exp=11100", {pc_we_a, if_id_we_a, ex_mem_we_a, if_id_clear_a, id_ex_clear_a}); end
      tick();
   endtask

   task automatic test_load_use();
      set_load5();
      #1;
      total++; if ({pc_we_a, if_id_we_a, id_ex_clear_a, ex_mem_we_a, if_id_clear_a} !== 5'b00110) begin bad++; $display("FAIL lu_a_outputs got=%b exp=00110", {pc_we_a, if_id_we_a, id_ex_clear_a, ex_mem_we_a, if_id_clear_a}); end
      total++; if ({pc_we_b, if_id_we_b, id_ex_clear_b} !== 3'b001) begin bad++; $display("FAIL lu_b_outputs got=%b exp=001", {pc_we_b, if_id_we_b, id_ex_clear_b}); end
      tick();
      idle();
      #1;
      total++; if (stall_cnt_a !== 16'd1) begin bad++; $display("FAIL lu_a_stall_cnt got=%0d exp=1", stall_cnt_a); end
      total++; if (pc_we_a !== 1'b1 || id_ex_clear_a !== 1'b0) begin bad++; $display("FAIL lu_a_after got=%b%b exp=10", pc_we_a, id_ex_clear_a); end
      total++; if (pc_we_b !== 1'b0 || id_ex_clear_b !== 1'b1) begin bad++; $display("FAIL lu_b_bubble2 got=%b%b exp=01", pc_we_b, id_ex_clear_b); end
      tick();
      #1;
      total++; if (pc_we_b !== 1'b0) begin bad++; $display("FAIL lu_b_bubble3 got=%b exp=0", pc_we_b); end
      tick();
      #1;
      total++; if (pc_we_b !== 1'b1 || stall_cnt_b !== 16'd3) begin bad++; $display("FAIL lu_b_done got=%b/%0d exp=1/3", pc_we_b, stall_cnt_b); end
   endtask

   task automatic test_operand_match();
      for (int i = 0; i < 5; i++) begin
         ex_mem_read = v_rd_en[i]; ex_rd = v_rd[i]; id_rs1 = v_rs1[i]; id_rs2 = v_rs2[i];
         id_uses_rs1 = v_u1[i]; id_uses_rs2 = v_u2[i];
         #1;
         total++; if (pc_we_a !== !v_exp[i] || id_ex_clear_a !== v_exp[i]) begin bad++; $display("FAIL match_vec%0d got=%b%b exp=%b%b", i, pc_we_a, id_ex_clear_a, !v_exp[i], v_exp[i]); end
         tick();
         idle();
         repeat (3) tick();
      end
      #1;
      total++; if (stall_cnt_a !== 16'd2 || stall_cnt_b !== 16'd6) begin bad++; $display("FAIL match_stall_cnts got=%0d/%0d exp=2/6", stall_cnt_a, stall_cnt_b); end
   endtask

   task automatic test_branch();
      ex_branch_taken = 1'b1;
      #1;
      total++; if ({pc_we_a, if_id_clear_a, id_ex_clear_a} !== 3'b111) begin bad++; $display("FAIL br_c1 got=%b exp=111", {pc_we_a, if_id_clear_a, id_ex_clear_a}); end
      tick();
      #1;
      // Still asserted: A is in FLUSH and must ignore it, B redirects again.
      total++; if ({pc_we_a, if_id_clear_a, id_ex_clear_a} !== 3'b111) begin bad++; $display("FAIL br_c2 got=%b exp=111", {pc_we_a, if_id_clear_a, id_ex_clear_a}); end
      total++; if (flush_cnt_a !== 16'd1) begin bad++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_cnt_a); end
      tick();
      idle();
      #1;
      total++; if (pc_we_a !== 1'b1 || if_id_clear_a !== 1'b0 || if_id_clear_b !== 1'b0) begin bad++; $display("FAIL br_run got=%b%b%b exp=100", pc_we_a, if_id_clear_a, if_id_clear_b); end
      total++; if (flush_cnt_a !== 16'd1 || flush_cnt_b !== 16'd2 || stall_cnt_a !== 16'd2) begin bad++; $display("FAIL br_cnts got=%0d/%0d/%0d exp=1/2/2", flush_cnt_a, flush_cnt_b, stall_cnt_a); end
   endtask

   task automatic test_freeze();
      dmem_busy = 1'b1; ex_branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if ({pc_we_a, if_id_we_a, ex_mem_we_a, if_id_clear_a, id_ex_clear_a} !== 5'b00000) begin bad++; $display("FAIL frz_c%0d got=%b exp=00000", i, {pc_we_a, if_id_we_a, ex_mem_we_a, if_id_clear_a, id_ex_clear_a}); end
         tick();
      end
      dmem_busy = 1'b0;
      #1;
      total++; if (stall_cnt_a !== 16'd5) begin bad++; $display("FAIL frz_stall_cnt got=%0d exp=5", stall_cnt_a); end
      total++; if ({pc_we_a, if_id_clear_a, id_ex_clear_a} !== 3'b111) begin bad++; $display("FAIL frz_deferred_br got=%b exp=111", {pc_we_a, if_id_clear_a, id_ex_clear_a}); end
      tick();
      // Freeze in the middle of the flush: the remaining flush cycle must survive it.
      ex_branch_taken = 1'b0; dmem_busy = 1'b1;
      #1;
      total++; if (if_id_clear_a !== 1'b0 || pc_we_a !== 1'b0) begin bad++; $display("FAIL frz_in_flush got=%b%b exp=00", if_id_clear_a, pc_we_a); end
      tick();
      dmem_busy = 1'b0;
      #1;
      total++; if (if_id_clear_a !== 1'b1 || pc_we_a !== 1'b1 || if_id_clear_b !== 1'b0) begin bad++; $display("FAIL frz_flush_resume got=%b%b%b exp=110", if_id_clear_a, pc_we_a, if_id_clear_b); end
      tick();
      #1;
      total++; if (if_id_clear_a !== 1'b0 || flush_cnt_a !== 16'd2 || flush_cnt_b !== 16'd3 || stall_cnt_a !== 16'd6) begin bad++; $display("FAIL frz_end got=%b/%0d/%0d/%0d exp=0/2/3/6", if_id_clear_a, flush_cnt_a, flush_cnt_b, stall_cnt_a); end
   endtask

   task automatic test_branch_vs_load();
      set_load5();
      ex_branch_taken = 1'b1;
      #1;
      total++; if ({pc_we_a, if_id_clear_a, id_ex_clear_a} !== 3'b111) begin bad++; $display("FAIL bvl_a got=%b exp=111", {pc_we_a, if_id_clear_a, id_ex_clear_a}); end
      total++; if ({pc_we_b, if_id_clear_b, id_ex_clear_b} !== 3'b111) begin bad++; $display("FAIL bvl_b got=%b exp=111", {pc_we_b, if_id_clear_b, id_ex_clear_b}); end
      tick();
      idle();
      tick();
      #1;
      total++; if (stall_cnt_a !== 16'd6 || stall_cnt_b !== 16'd10 || flush_cnt_a !== 16'd3 || flush_cnt_b !== 16'd4) begin bad++; $display("FAIL bvl_cnts got=%0d/%0d/%0d/%0d exp=6/10/3/4", stall_cnt_a, stall_cnt_b, flush_cnt_a, flush_cnt_b); end
   endtask

   task automatic test_saturate();
      dmem_busy = 1'b1;
      repeat (65534 - 6) tick();
      #1;
      total++; if (stall_cnt_a !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%0h exp=fffe", stall_cnt_a); end
      tick();
      #1;
      total++; if (stall_cnt_a !== 16'hFFFF) begin bad++; $display("FAIL sat_max got=%0h exp=ffff", stall_cnt_a); end
      repeat (4) tick();
      #1;
      total++; if (stall_cnt_a !== 16'hFFFF || stall_cnt_b !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%0h/%0h exp=ffff/ffff", stall_cnt_a, stall_cnt_b); end
      dmem_busy = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_stall();
      set_load5();
      tick();
      idle();
      #1;
      total++; if (pc_we_b !== 1'b0 || id_ex_clear_b !== 1'b1) begin bad++; $display("FAIL rms_in_stall got=%b%b exp=01", pc_we_b, id_ex_clear_b); end
      rst_n = 1'b0;
      #1;
      total++; if ({pc_we_b, if_id_we_b, ex_mem_we_b, if_id_clear_b, id_ex_clear_b} !== 5'b00011) begin bad++; $display("FAIL rms_outputs got=%b exp=00011", {pc_we_b, if_id_we_b, ex_mem_we_b, if_id_clear_b, id_ex_clear_b}); end
      total++; if (stall_cnt_a !== 16'd0 || stall_cnt_b !== 16'd0 || flush_cnt_a !== 16'd0 || flush_cnt_b !== 16'd0) begin bad++; $display("FAIL rms_cnts got=%0h/%0h/%0h/%0h exp=0/0/0/0", stall_cnt_a, stall_cnt_b, flush_cnt_a, flush_cnt_b); end
      tick();
      rst_n = 1'b1;
      #1;
      total++; if (pc_we_b !== 1'b1 || id_ex_clear_b !== 1'b0) begin bad++; $display("FAIL rms_run got=%b%b exp=10", pc_we_b, id_ex_clear_b); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_operand_match();
      test_branch();
      test_freeze();
      test_branch_vs_load();
      test_saturate();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
